// File: rtl/ram2p_wrsched.sv
// Write/read scheduler in front of a 1R1W byte-enable RAM: zero sweep, A/B write arbitration, collision merge.
// Optional: define RAM2P_BYPASS_EN for registered write-first bypass on same-cycle read/write collisions.
module ram2p_wrsched #(
  parameter  int DEPTH  = 1024,
  parameter  int WIDTH  = 68,
  parameter  int STARVE = 3,
  localparam int AW     = $clog2(DEPTH),
  localparam int BW     = (WIDTH - 1) / 8 + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_FlushReq,
  output logic             o_FlushBusy,
  output logic             o_FlushDone,
  input  logic             i_WrReqA,
  input  logic [AW-1:0]    i_WrAdrA,
  input  logic [WIDTH-1:0] i_WrDataA,
  input  logic [BW-1:0]    i_WrBEA,
  output logic             o_WrGntA,
  input  logic             i_WrReqB,
  input  logic [AW-1:0]    i_WrAdrB,
  input  logic [WIDTH-1:0] i_WrDataB,
  input  logic [BW-1:0]    i_WrBEB,
  output logic             o_WrGntB,
  input  logic             i_RdEn,
  input  logic [AW-1:0]    i_RdAdr,
  output logic             o_RdReady,
  output logic [WIDTH-1:0] o_RdData,
  output logic             o_RamCE1,
  output logic [AW-1:0]    o_RamRA1,
  input  logic [WIDTH-1:0] i_RamRD1,
  output logic             o_RamCE2,
  output logic             o_RamWE2,
  output logic [AW-1:0]    o_RamWA2,
  output logic [WIDTH-1:0] o_RamWD2,
  output logic [BW-1:0]    o_RamBWE2
);

  typedef enum logic {FLUSH, IDLE} state_t;

  localparam int            SW         = $clog2(STARVE + 2);
  localparam logic [AW-1:0] LAST_ADR   = AW'(DEPTH - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  state_t        r_state;
  state_t        w_stateNext;
  logic [AW-1:0] r_sweepCnt;
  logic [AW-1:0] w_sweepCntNext;
  logic [SW-1:0] r_starveCnt;
  logic [SW-1:0] w_starveCntNext;
  logic          r_flushDone;
  logic          w_flushDoneNext;
  logic          w_gntA;
  logic          w_gntB;
  logic          w_rdAcc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FLUSH;
      r_sweepCnt  <= '0;
      r_starveCnt <= '0;
      r_flushDone <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_sweepCnt  <= w_sweepCntNext;
      r_starveCnt <= w_starveCntNext;
      r_flushDone <= w_flushDoneNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_sweepCntNext  = r_sweepCnt;
    w_starveCntNext = r_starveCnt;
    w_flushDoneNext = 1'b0;
    w_gntA          = 1'b0;
    w_gntB          = 1'b0;
    o_RamCE2        = 1'b0;
    o_RamWE2        = 1'b0;
    o_RamWA2        = '0;
    o_RamWD2        = '0;
    o_RamBWE2       = '0;
    if (!reset && r_state == IDLE) begin
      // A is the default winner unless B has already lost STARVE times in a row.
      w_gntA = i_WrReqA && !(i_WrReqB && r_starveCnt == STARVE_MAX);
      w_gntB = i_WrReqB && !w_gntA;
      if (w_gntA) begin
        o_RamCE2  = 1'b1;
        o_RamWE2  = 1'b1;
        o_RamWA2  = i_WrAdrA;
        o_RamWD2  = i_WrDataA;
        o_RamBWE2 = i_WrBEA;
      end else if (w_gntB) begin
        o_RamCE2  = 1'b1;
        o_RamWE2  = 1'b1;
        o_RamWA2  = i_WrAdrB;
        o_RamWD2  = i_WrDataB;
        o_RamBWE2 = i_WrBEB;
      end
      if (!i_WrReqB || w_gntB) begin
        w_starveCntNext = '0;
      end else begin
        w_starveCntNext = r_starveCnt + 1'b1;
      end
      if (i_FlushReq) begin
        w_stateNext    = FLUSH;
        w_sweepCntNext = '0;
      end
    end else if (!reset) begin
      o_RamCE2       = 1'b1;
      o_RamWE2       = 1'b1;
      o_RamWA2       = r_sweepCnt;
      o_RamWD2       = '0;
      o_RamBWE2      = '1;
      w_sweepCntNext = r_sweepCnt + 1'b1;
      if (!i_WrReqB) begin
        w_starveCntNext = '0;
      end
      if (r_sweepCnt == LAST_ADR) begin
        w_stateNext     = IDLE;
        w_flushDoneNext = 1'b1;
      end
    end
  end

  assign o_FlushBusy = reset || (r_state == FLUSH);
  assign o_FlushDone = r_flushDone && !reset;
  assign o_RdReady   = !o_FlushBusy;
  assign o_WrGntA    = w_gntA;
  assign o_WrGntB    = w_gntB;
  assign w_rdAcc     = i_RdEn && o_RdReady;
  assign o_RamCE1    = w_rdAcc;
  assign o_RamRA1    = i_RdAdr;

`ifdef RAM2P_BYPASS_EN
  logic             r_coll;
  logic [WIDTH-1:0] r_bypData;
  logic [BW-1:0]    r_bypBE;
  logic [WIDTH-1:0] w_bypMask;

  // Capture the colliding write so it can be laid over whatever the RAM returns next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_rdAcc && (w_gntA || w_gntB) && (i_RdAdr == o_RamWA2);
    end
    r_bypData <= o_RamWD2;
    r_bypBE   <= o_RamBWE2;
  end

  always_comb begin
    w_bypMask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bypMask[i] = r_bypBE[i / 8];
    end
  end

  assign o_RdData = r_coll ? ((i_RamRD1 & ~w_bypMask) | (r_bypData & w_bypMask)) : i_RamRD1;
`else
  assign o_RdData = i_RamRD1;
`endif

endmodule

// File: doc/ram2p_wrsched.md
Name: ram2p_wrsched

Overview:
Access scheduler in front of one 2-port 1R1W byte-enable RAM (cache data/tag/state arrays).
- After reset or on request, sweeps the whole array to zero.
- Arbitrates the single write port between a fill requester (A) and a store requester (B), with a starvation guard for B.
- Gates the read port and resolves same-cycle read/write address collisions so read data is deterministic, independent of the RAM's read-first/write-first semantics.

Parameters:
DEPTH, 1024, number of RAM words; AW = $clog2(DEPTH)
WIDTH, 68, bits per word; BW = (WIDTH-1)/8+1 byte-enable lanes
STARVE, 3, consecutive cycles B may lose before B is forced to win

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
FlushReq  in  1  request a full-array zero sweep
FlushBusy  out  1  sweep in progress; reads and writes blocked
FlushDone  out  1  one-cycle pulse after the last sweep write
WrReqA  in  1  fill write request
WrAdrA  in  AW  fill address
WrDataA  in  WIDTH  fill data
WrBEA  in  BW  fill byte enables
WrGntA  out  1  fill write accepted this cycle
WrReqB  in  1  store write request
WrAdrB  in  AW  store address
WrDataB  in  WIDTH  store data
WrBEB  in  BW  store byte enables
WrGntB  out  1  store write accepted this cycle
RdEn  in  1  read request
RdAdr  in  AW  read address
RdReady  out  1  read accepted when RdEn & RdReady
RdData  out  WIDTH  read data, valid the cycle after acceptance
RamCE1  out  1  RAM read-port enable
RamRA1  out  AW  RAM read address
RamRD1  in  WIDTH  RAM read data
RamCE2  out  1  RAM write-port enable
RamWE2  out  1  RAM write enable
RamWA2  out  AW  RAM write address
RamWD2  out  WIDTH  RAM write data
RamBWE2  out  BW  RAM byte enables

Behaviour:
- States: FLUSH, IDLE. Reset forces FLUSH with sweep counter 0 and starve counter 0.
- While reset is high: RamCE2 = RamWE2 = 0, WrGntA = WrGntB = 0, RdReady = 0, FlushDone = 0, FlushBusy = 1.
- FLUSH, one write per cycle:
  - RamCE2 = RamWE2 = 1, RamWA2 = counter, RamWD2 = 0, RamBWE2 = all ones.
  - Counter increments each cycle. After the write at DEPTH-1, next state is IDLE and FlushDone = 1 for exactly that first IDLE cycle.
  - Sweep takes exactly DEPTH cycles.
  - FlushReq during FLUSH is ignored; no restart, no extension.
  - Reset mid-sweep restarts the sweep at 0.
- IDLE:
  - FlushReq = 1 moves to FLUSH next cycle with counter 0. Writes and reads in that same cycle are still serviced.
  - FlushBusy = (state == FLUSH). RdReady = ~FlushBusy.
- Write arbitration in IDLE (combinational grant, same cycle):
  - A wins by default. B wins if A is idle.
  - Starve counter: increments when B requests and loses; clears when B is granted or B is not requesting.
  - When the counter equals STARVE and both request, B wins and A is not granted.
  - The winner drives RamWA2/RamWD2/RamBWE2 with RamCE2 = RamWE2 = 1. With no grant, RamCE2 = RamWE2 = 0.
  - No grant is issued in FLUSH.
- Read:
  - RamCE1 = RdEn & RdReady, RamRA1 = RdAdr.
  - RdData is valid exactly one cycle after acceptance and is undefined in other cycles.
- Collision (read accepted and write granted in the same cycle with RdAdr == write address):
  - RdData = old word with the granted byte lanes replaced by the written data, i.e. write-first semantics.
  - The top partial lane covers WIDTH%8 bits when WIDTH is not a multiple of 8.
- No other hazards are handled. A write in the cycle after a read does not affect that read's RdData.

Optional Feature:
RAM2P_BYPASS_EN
- Defined: RdData comes from a registered bypass. The controller registers the collision flag, write data and byte enables, and merges them over RamRD1 per byte lane, giving write-first semantics regardless of the macro.
- Undefined: RdData = RamRD1 directly, no bypass registers; same-cycle collision data is macro-dependent and unspecified.

Test Plan:
- Reset one cycle, then run: RamWE2 high 1024 consecutive cycles, RamWA2 0..1023, data 0, BWE all ones. FlushDone pulses at cycle 1025. RdReady and grants stay low throughout.
- IDLE with WrReqA = WrReqB = 1 held continuously -> grant pattern A,A,A,B,A,A,A,B,...; with WrReqB only -> WrGntB = 1 every cycle.
- Write 0x123456789ABCDEF01 to address 5 via A, then read address 5 -> RdData = 0x123456789ABCDEF01 the next cycle.
- With RAM2P_BYPASS_EN: address 7 holds all ones; same cycle read 7 and B writes data 0 with BWE = 0x001 -> RdData = all ones except bits [7:0] = 0x00.
- FlushReq at IDLE, then FlushReq again mid-sweep, then reset at sweep count 500 -> sweep restarts at 0 and FlushDone pulses once, 1024 cycles after reset deasserts.
- Read accepted the same cycle FlushReq is asserted -> valid RdData next cycle; RdReady = 0 for the following 1024 cycles.
